// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - shared card, category and score types for the streaming hand evaluator
package poker_pkg;

    localparam int          HAND_N   = 5;
    localparam logic [3:0]  RANK_MIN = 4'd2;
    localparam logic [3:0]  RANK_ACE = 4'hE;
    localparam int          NUM_CATS = 10;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [3:0] {
        CAT_HIGH       = 4'd0,
        CAT_PAIR       = 4'd1,
        CAT_TWO_PAIR   = 4'd2,
        CAT_TRIPS      = 4'd3,
        CAT_STRAIGHT   = 4'd4,
        CAT_FLUSH      = 4'd5,
        CAT_FULL_HOUSE = 4'd6,
        CAT_QUADS      = 4'd7,
        CAT_STR_FLUSH  = 4'd8,
        CAT_ROYAL      = 4'd9
    } hand_cat_e;

    typedef logic [23:0] score_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/poker_hand_classifier.sv
// rtl/poker_hand_classifier.sv - combinational category/tiebreak/error for a rank-descending 5-card hand
// Optional: WHEEL_STRAIGHT_EN makes A-5-4-3-2 a (non-royal) straight with the ace scored as 1.
module poker_hand_classifier
    import poker_pkg::*;
(
    input  card_t [HAND_N-1:0] cards_i,
    output hand_cat_e          cat_o,
    output logic [19:0]        tiebreak_o,
    output logic               err_o
);

    logic [3:0] r    [HAND_N];
    logic [2:0] mult [HAND_N];
    logic [6:0] key  [HAND_N];
    logic [2:0] pos  [HAND_N];
    logic [3:0] t    [HAND_N];
    logic [2:0] n_pair_cards;
    logic       has_trips;
    logic       has_quads;
    logic       flush;
    logic       run;
    logic       straight;
    logic [3:0] top;
`ifdef WHEEL_STRAIGHT_EN
    logic       wheel;
`endif

    always_comb begin
        err_o = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < HAND_N; i++) begin
            r[i] = cards_i[i].rank;
            if (cards_i[i].rank < RANK_MIN || cards_i[i].rank > RANK_ACE) err_o = 1'b1;
            if (cards_i[i].suit != cards_i[0].suit) flush = 1'b0;
            for (int j = i + 1; j < HAND_N; j++) begin
                if (cards_i[i] == cards_i[j]) err_o = 1'b1;
            end
        end
    end

    // Tiebreak order is (multiplicity desc, rank desc); pos[] is each card's slot in that order.
    always_comb begin
        for (int i = 0; i < HAND_N; i++) begin
            mult[i] = 3'd0;
            for (int j = 0; j < HAND_N; j++) begin
                if (r[j] == r[i]) mult[i] = mult[i] + 3'd1;
            end
            key[i] = {mult[i], r[i]};
        end
        for (int i = 0; i < HAND_N; i++) begin
            pos[i] = 3'd0;
            for (int j = 0; j < HAND_N; j++) begin
                if (key[j] > key[i] || (j < i && key[j] == key[i])) pos[i] = pos[i] + 3'd1;
            end
        end
        for (int p = 0; p < HAND_N; p++) begin
            t[p] = 4'd0;
            for (int i = 0; i < HAND_N; i++) begin
                if (pos[i] == 3'(p)) t[p] = r[i];
            end
        end
    end

    always_comb begin
        n_pair_cards = 3'd0;
        has_trips    = 1'b0;
        has_quads    = 1'b0;
        for (int i = 0; i < HAND_N; i++) begin
            if (mult[i] == 3'd2) n_pair_cards = n_pair_cards + 3'd1;
            if (mult[i] == 3'd3) has_trips = 1'b1;
            if (mult[i] == 3'd4) has_quads = 1'b1;
        end
        run = (r[0] > r[1]) && (r[1] > r[2]) && (r[2] > r[3]) && (r[3] > r[4])
              && ((r[0] - r[4]) == 4'd4);
`ifdef WHEEL_STRAIGHT_EN
        wheel    = (r[0] == RANK_ACE) && (r[1] == 4'd5) && (r[2] == 4'd4)
                   && (r[3] == 4'd3) && (r[4] == 4'd2);
        straight = run || wheel;
        top      = wheel ? 4'd5 : r[0];
`else
        straight = run;
        top      = r[0];
`endif
    end

    always_comb begin
        cat_o      = CAT_HIGH;
        tiebreak_o = {t[0], t[1], t[2], t[3], t[4]};
        if (err_o) begin
            cat_o      = CAT_HIGH;
            tiebreak_o = 20'd0;
        end else if (straight && flush) begin
            cat_o      = (top == RANK_ACE) ? CAT_ROYAL : CAT_STR_FLUSH;
            tiebreak_o = {5{top}};
        end else if (has_quads) begin
            cat_o = CAT_QUADS;
        end else if (has_trips && n_pair_cards == 3'd2) begin
            cat_o = CAT_FULL_HOUSE;
        end else if (flush) begin
            cat_o = CAT_FLUSH;
        end else if (straight) begin
            cat_o      = CAT_STRAIGHT;
            tiebreak_o = {5{top}};
        end else if (has_trips) begin
            cat_o = CAT_TRIPS;
        end else if (n_pair_cards == 3'd4) begin
            cat_o = CAT_TWO_PAIR;
        end else if (n_pair_cards == 3'd2) begin
            cat_o = CAT_PAIR;
        end
    end

endmodule

// File: rtl/poker_hand_evaluator_seq.sv
// rtl/poker_hand_evaluator_seq.sv - streaming hand loader/sorter, per-hand result and round winner
// Optional: WHEEL_STRAIGHT_EN (handled in poker_hand_classifier) enables A-5 low straights.
module poker_hand_evaluator_seq
    import poker_pkg::*;
#(
    parameter  int NUM_PLAYERS = 4,
    parameter  int HAND_SIZE   = 5,
    localparam int PIDX_W      = $clog2(NUM_PLAYERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              round_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_card,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PIDX_W-1:0] res_player,
    output logic [3:0]        res_cat,
    output logic [23:0]       res_score,
    output logic              res_err,
    output logic              win_valid,
    output logic [PIDX_W-1:0] win_player,
    output logic              win_tie
);

    if (HAND_SIZE != HAND_N) begin : g_hand_size_check
        $error("poker_hand_evaluator_seq: HAND_SIZE must be 5");
    end

    localparam logic [PIDX_W-1:0] LAST_P = PIDX_W'(NUM_PLAYERS - 1);

    state_e                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    card_t [HAND_N-1:0]       hand_q, hand_d;
    logic [PIDX_W-1:0]        player_q, player_d;
    logic                     up_q, up_d;
    logic                     res_valid_q, res_valid_d;
    hand_cat_e                res_cat_q, res_cat_d;
    score_t                   res_score_q, res_score_d;
    logic                     res_err_q, res_err_d;
    logic                     best_valid_q, best_valid_d;
    score_t                   best_score_q, best_score_d;
    logic [PIDX_W-1:0]        best_idx_q, best_idx_d;
    logic                     best_tie_q, best_tie_d;

    card_t                    in_c;
    card_t [HAND_N-1:0]       ins_hand;
    logic  [HAND_N-1:0]       ge;
    logic                     accept;
    logic                     res_hs;
    hand_cat_e                cls_cat;
    logic [19:0]              cls_tb;
    logic                     cls_err;
    logic                     m_valid;
    score_t                   m_score;
    logic [PIDX_W-1:0]        m_idx;
    logic                     m_tie;

    assign in_c     = in_card;
    assign in_ready = up_q && (state_q == ST_LOAD) && !round_clr;
    assign accept   = in_valid && in_ready;
    assign res_hs   = res_valid_q && res_ready;

    // ge is a prefix mask over the filled slots; the new card lands right after
    // the last entry of equal or higher rank, so equal ranks keep arrival order.
    always_comb begin
        for (int i = 0; i < HAND_N; i++) begin
            ge[i] = (3'(i) < cnt_q) && (hand_q[i].rank >= in_c.rank);
        end
        ins_hand[0] = ge[0] ? hand_q[0] : in_c;
        for (int i = 1; i < HAND_N; i++) begin
            if (ge[i])          ins_hand[i] = hand_q[i];
            else if (ge[i - 1]) ins_hand[i] = in_c;
            else                ins_hand[i] = hand_q[i - 1];
        end
    end

    poker_hand_classifier u_classifier (
        .cards_i    (hand_q),
        .cat_o      (cls_cat),
        .tiebreak_o (cls_tb),
        .err_o      (cls_err)
    );

    // Running best with the pending result folded in; committed on handshake.
    always_comb begin
        m_valid = best_valid_q;
        m_score = best_score_q;
        m_idx   = best_idx_q;
        m_tie   = best_tie_q;
        if (!res_err_q) begin
            if (!best_valid_q || res_score_q > best_score_q) begin
                m_valid = 1'b1;
                m_score = res_score_q;
                m_idx   = player_q;
                m_tie   = 1'b0;
            end else if (res_score_q == best_score_q) begin
                m_tie = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hand_d       = hand_q;
        player_d     = player_q;
        up_d         = 1'b1;
        res_valid_d  = res_valid_q;
        res_cat_d    = res_cat_q;
        res_score_d  = res_score_q;
        res_err_d    = res_err_q;
        best_valid_d = best_valid_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        best_tie_d   = best_tie_q;
        if (round_clr) begin
            state_d      = ST_LOAD;
            cnt_d        = 3'd0;
            hand_d       = '0;
            player_d     = '0;
            res_valid_d  = 1'b0;
            res_cat_d    = CAT_HIGH;
            res_score_d  = '0;
            res_err_d    = 1'b0;
            best_valid_d = 1'b0;
            best_score_d = '0;
            best_idx_d   = '0;
            best_tie_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        hand_d = ins_hand;
                        if (cnt_q == 3'(HAND_N - 1)) begin
                            cnt_d   = 3'd0;
                            state_d = ST_EVAL;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_EVAL: begin
                    res_valid_d = 1'b1;
                    res_cat_d   = cls_cat;
                    res_score_d = {cls_cat, cls_tb};
                    res_err_d   = cls_err;
                    state_d     = ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_hs) begin
                        res_valid_d = 1'b0;
                        state_d     = ST_LOAD;
                        if (player_q == LAST_P) begin
                            player_d     = '0;
                            best_valid_d = 1'b0;
                            best_score_d = '0;
                            best_idx_d   = '0;
                            best_tie_d   = 1'b0;
                        end else begin
                            player_d     = player_q + PIDX_W'(1);
                            best_valid_d = m_valid;
                            best_score_d = m_score;
                            best_idx_d   = m_idx;
                            best_tie_d   = m_tie;
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            cnt_q        <= 3'd0;
            hand_q       <= '0;
            player_q     <= '0;
            up_q         <= 1'b0;
            res_valid_q  <= 1'b0;
            res_cat_q    <= CAT_HIGH;
            res_score_q  <= '0;
            res_err_q    <= 1'b0;
            best_valid_q <= 1'b0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            best_tie_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hand_q       <= hand_d;
            player_q     <= player_d;
            up_q         <= up_d;
            res_valid_q  <= res_valid_d;
            res_cat_q    <= res_cat_d;
            res_score_q  <= res_score_d;
            res_err_q    <= res_err_d;
            best_valid_q <= best_valid_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            best_tie_q   <= best_tie_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_player = player_q;
    assign res_cat    = res_cat_q;
    assign res_score  = res_score_q;
    assign res_err    = res_err_q;
    assign win_valid  = res_valid_q && (player_q == LAST_P);
    assign win_player = (win_valid && m_valid) ? m_idx : '0;
    assign win_tie    = win_valid && (m_valid ? m_tie : 1'b1);

endmodule

// File: tb/tb_poker_hand_evaluator_seq.sv
// tb/tb_poker_hand_evaluator_seq.sv - self-checking bench with a histogram-based poker reference model
module tb_poker_hand_evaluator_seq;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        round_clr;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_card;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_player;
    logic [3:0]  res_cat;
    logic [23:0] res_score;
    logic        res_err;
    logic        win_valid;
    logic [1:0]  win_player;
    logic        win_tie;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poker_hand_evaluator_seq #(.NUM_PLAYERS(NP), .HAND_SIZE(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .round_clr  (round_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_card    (in_card),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_player (res_player),
        .res_cat    (res_cat),
        .res_score  (res_score),
        .res_err    (res_err),
        .win_valid  (win_valid),
        .win_player (win_player),
        .win_tie    (win_tie)
    );

    function automatic logic [5:0] cd(input int s, input int r);
        return {2'(s), 4'(r)};
    endfunction

    function automatic logic [29:0] mk5(input logic [5:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    // Reference: rank histogram, then categories and kicker order straight from poker rules.
    function automatic void ref_hand(input logic [29:0] h, output logic [3:0] cat,
                                     output logic [23:0] score, output logic err);
        int cnt[16];
        int rk[5];
        int st[5];
        int tb[$];
        int mx, mn, pairs, top;
        bit flush, straight, trips, quads, distinct;
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rk[i] = int'(h[6*i +: 4]);
            st[i] = int'(h[6*i+4 +: 2]);
            cnt[rk[i]]++;
            if (rk[i] < 2 || rk[i] > 14) err = 1'b1;
            for (int j = 0; j < i; j++) if (rk[j] == rk[i] && st[j] == st[i]) err = 1'b1;
        end
        if (err) begin
            cat = 4'd0; score = 24'd0; return;
        end
        flush = 1'b1; mx = 0; mn = 99; pairs = 0; trips = 0; quads = 0; distinct = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (st[i] != st[0]) flush = 1'b0;
            if (rk[i] > mx) mx = rk[i];
            if (rk[i] < mn) mn = rk[i];
        end
        for (int r = 2; r <= 14; r++) begin
            if (cnt[r] == 2) pairs++;
            if (cnt[r] == 3) trips = 1'b1;
            if (cnt[r] == 4) quads = 1'b1;
            if (cnt[r] > 1) distinct = 1'b0;
        end
        straight = distinct && (mx - mn == 4);
        top = mx;
`ifdef WHEEL_STRAIGHT_EN
        if (distinct && cnt[14] == 1 && cnt[2] == 1 && cnt[3] == 1 && cnt[4] == 1 && cnt[5] == 1) begin
            straight = 1'b1; top = 5;
        end
`endif
        for (int m = 4; m >= 1; m--)
            for (int r = 14; r >= 2; r--)
                if (cnt[r] == m) for (int k = 0; k < m; k++) tb.push_back(r);
        if (straight) begin
            tb.delete();
            for (int k = 0; k < 5; k++) tb.push_back(top);
        end
        if (straight && flush)   cat = (top == 14) ? 4'd9 : 4'd8;
        else if (quads)          cat = 4'd7;
        else if (trips && pairs) cat = 4'd6;
        else if (flush)          cat = 4'd5;
        else if (straight)       cat = 4'd4;
        else if (trips)          cat = 4'd3;
        else if (pairs == 2)     cat = 4'd2;
        else if (pairs == 1)     cat = 4'd1;
        else                     cat = 4'd0;
        score = {cat, 4'(tb[0]), 4'(tb[1]), 4'(tb[2]), 4'(tb[3]), 4'(tb[4])};
    endfunction

    function automatic void ref_winner(input logic [95:0] sc, input logic [3:0] er,
                                       output logic [1:0] wp, output logic wt);
        int best = -1;
        int bi = 0;
        int n = 0;
        for (int p = 0; p < NP; p++)
            if (!er[p] && int'(sc[24*p +: 24]) > best) begin
                best = int'(sc[24*p +: 24]); bi = p;
            end
        if (best < 0) begin
            wp = 2'd0; wt = 1'b1;
        end else begin
            for (int p = 0; p < NP; p++) if (!er[p] && int'(sc[24*p +: 24]) == best) n++;
            wp = 2'(bi); wt = (n > 1);
        end
    endfunction

    function automatic logic [29:0] rand_hand(input int mode);
        logic [29:0] h;
        int rk[5];
        int base, s, j, tmp;
        bit same;
        s = $urandom_range(3, 0);
        same = (mode == 2) || (mode == 3 && $urandom_range(1, 0) == 1);
        for (int i = 0; i < 5; i++) rk[i] = $urandom_range(14, 2);
        if (mode == 1) begin
            base = $urandom_range(12, 2);
            for (int i = 0; i < 5; i++) rk[i] = base + $urandom_range(2, 0);
        end else if (mode == 3) begin
            base = $urandom_range(10, 1);
            for (int i = 0; i < 5; i++) rk[i] = (base + i == 1) ? 14 : base + i;
            for (int i = 4; i > 0; i--) begin
                j = $urandom_range(i, 0); tmp = rk[i]; rk[i] = rk[j]; rk[j] = tmp;
            end
        end
        for (int i = 0; i < 5; i++) h[6*i +: 6] = cd(same ? s : $urandom_range(3, 0), rk[i]);
        if (mode == 4) begin
            j = $urandom_range(4, 1);
            if ($urandom_range(1, 0) == 1) h[6*j +: 6] = h[5:0];
            else h[6*j +: 4] = 4'($urandom_range(2, 0) == 0 ? 15 : $urandom_range(1, 0));
        end
        return h;
    endfunction

    task automatic send_card(input logic [5:0] c, output bit ok);
        int n = 0;
        in_card  = c;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic play_hand(input logic [29:0] h, output logic [3:0] cat, output logic [23:0] sc,
                             output logic er, output logic [1:0] pl, output logic wv,
                             output logic [1:0] wp, output logic wt, output bit ok);
        bit c_ok;
        int n = 0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_card(h[6*i +: 6], c_ok);
            if (!c_ok) ok = 1'b0;
        end
        while (!res_valid && n < 20) begin
            @(negedge clk); n++;
        end
        if (!res_valid) ok = 1'b0;
        cat = res_cat; sc = res_score; er = res_err; pl = res_player;
        wv = win_valid; wp = win_player; wt = win_tie;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; round_clr = 1'b0; in_valid = 1'b0; in_card = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || win_valid !== 1'b0 || res_score !== 24'd0 ||
            res_cat !== 4'd0 || res_err !== 1'b0 || res_player !== 2'd0 || win_player !== 2'd0 || win_tie !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b res_valid=%b win_valid=%b score=%h, all required 0", in_ready, res_valid, win_valid, res_score);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_royal_latency;
        logic [5:0] seq[5];
        bit ok, all_ok;
        seq = '{cd(2, 14), cd(2, 12), cd(2, 10), cd(2, 13), cd(2, 11)};
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_card(seq[i], ok);
            if (!ok) all_ok = 1'b0;
        end
        checks++;
        if (!all_ok || res_valid !== 1'b0) begin
            errors++; $display("FAIL royal_eval_cycle: accepted=%b res_valid=%b required 1/0", all_ok, res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_cat !== 4'd9 || res_score !== 24'h9EEEEE || res_err !== 1'b0 ||
            res_player !== 2'd0 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL royal_result: valid=%b cat=%0d score=%h err=%b player=%0d wv=%b required 1/9/9eeeee/0/0/0", res_valid, res_cat, res_score, res_err, res_player, win_valid);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL royal_handshake: res_valid=%b in_ready=%b required 0/1", res_valid, in_ready);
        end
    endtask

    task automatic test_wheel;
        logic [3:0] cat; logic [23:0] sc; logic er, wv, wt; logic [1:0] pl, wp; bit ok;
        logic [3:0] ecat; logic [23:0] esc;
`ifdef WHEEL_STRAIGHT_EN
        ecat = 4'd4; esc = 24'h455555;
`else
        ecat = 4'd0; esc = 24'h0E5432;
`endif
        play_hand(mk5(cd(0, 14), cd(1, 2), cd(2, 3), cd(3, 4), cd(0, 5)), cat, sc, er, pl, wv, wp, wt, ok);
        checks++;
        if (!ok || cat !== ecat || sc !== esc || er !== 1'b0 || pl !== 2'd1) begin
            errors++; $display("FAIL wheel: ok=%b cat=%0d score=%h player=%0d required cat=%0d score=%h player=1", ok, cat, sc, pl, ecat, esc);
        end
    endtask

    task automatic test_full_house;
        logic [3:0] cat; logic [23:0] sc; logic er, wv, wt; logic [1:0] pl, wp; bit ok;
        play_hand(mk5(cd(0, 9), cd(0, 7), cd(1, 9), cd(1, 7), cd(2, 7)), cat, sc, er, pl, wv, wp, wt, ok);
        checks++;
        if (!ok || cat !== 4'd6 || sc !== 24'h677799 || er !== 1'b0 || pl !== 2'd2 || wv !== 1'b0) begin
            errors++; $display("FAIL full_house: ok=%b cat=%0d score=%h player=%0d wv=%b required 6/677799/2/0", ok, cat, sc, pl, wv);
        end
    endtask

    task automatic test_duplicate;
        logic [3:0] cat; logic [23:0] sc; logic er, wv, wt; logic [1:0] pl, wp; bit ok;
        play_hand(mk5(cd(1, 13), cd(0, 4), cd(1, 13), cd(3, 8), cd(2, 2)), cat, sc, er, pl, wv, wp, wt, ok);
        checks++;
        if (!ok || er !== 1'b1 || cat !== 4'd0 || sc !== 24'd0 || pl !== 2'd3) begin
            errors++; $display("FAIL duplicate: ok=%b err=%b cat=%0d score=%h player=%0d required 1/0/0/3", ok, er, cat, sc, pl);
        end
        checks++;
        if (wv !== 1'b1 || wp !== 2'd0 || wt !== 1'b0) begin
            errors++; $display("FAIL round1_winner: wv=%b wp=%0d tie=%b required 1/0/0", wv, wp, wt);
        end
    endtask

    task automatic test_tie;
        logic [29:0] hands[4];
        logic [3:0] cat; logic [23:0] sc; logic er, wv, wt; logic [1:0] pl, wp; bit ok;
        hands[0] = mk5(cd(0, 9), cd(1, 7), cd(2, 4), cd(3, 3), cd(0, 2));
        hands[1] = mk5(cd(1, 8), cd(1, 13), cd(1, 3), cd(1, 10), cd(1, 5));
        hands[2] = mk5(cd(0, 11), cd(1, 11), cd(2, 4), cd(3, 3), cd(0, 2));
        hands[3] = mk5(cd(3, 5), cd(3, 3), cd(3, 13), cd(3, 8), cd(3, 10));
        for (int p = 0; p < NP; p++) begin
            play_hand(hands[p], cat, sc, er, pl, wv, wp, wt, ok);
            checks++;
            if (!ok || pl !== 2'(p) || ((p == 1 || p == 3) && sc !== 24'h5DA853) || wv !== (p == 3)) begin
                errors++; $display("FAIL tie_hand%0d: ok=%b player=%0d score=%h wv=%b", p, ok, pl, sc, wv);
            end
        end
        checks++;
        if (wp !== 2'd1 || wt !== 1'b1) begin
            errors++; $display("FAIL tie_winner: wp=%0d tie=%b required 1/1", wp, wt);
        end
    endtask

    task automatic test_backpressure;
        logic [29:0] h;
        logic [3:0] ecat; logic [23:0] esc; logic eer;
        logic [23:0] held;
        bit ok, c_ok, bad;
        int n = 0;
        h = mk5(cd(0, 6), cd(1, 6), cd(2, 6), cd(3, 12), cd(0, 12));
        ref_hand(h, ecat, esc, eer);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_card(h[6*i +: 6], c_ok);
            if (!c_ok) ok = 1'b0;
        end
        while (!res_valid && n < 20) begin
            @(negedge clk); n++;
        end
        held = res_score;
        checks++;
        if (!ok || res_valid !== 1'b1 || held !== esc || res_player !== 2'd0) begin
            errors++; $display("FAIL bp_result: ok=%b valid=%b score=%h player=%0d required 1/%h/0", ok, res_valid, held, res_player, esc);
        end
        in_valid = 1'b1; in_card = cd(1, 9);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_score !== held || res_player !== 2'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold: in_ready=%b res_valid=%b score=%h required 0/1/%h", in_ready, res_valid, res_score, held);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: in_ready=%b res_valid=%b required 1/0", in_ready, res_valid);
        end
    endtask

    task automatic test_round_clr;
        logic [29:0] hands[4];
        logic [95:0] scs; logic [3:0] ers;
        logic [3:0] cat, ecat; logic [23:0] sc, esc; logic er, eer, wv, wt, ewt; logic [1:0] pl, wp, ewp;
        bit ok;
        play_hand(mk5(cd(3, 14), cd(3, 13), cd(3, 12), cd(3, 11), cd(3, 10)), cat, sc, er, pl, wv, wp, wt, ok);
        checks++;
        if (!ok || pl !== 2'd1 || cat !== 4'd9) begin
            errors++; $display("FAIL clr_pre_hand: ok=%b player=%0d cat=%0d required 1/9", ok, pl, cat);
        end
        for (int i = 0; i < 3; i++) send_card(cd(i, 4 + i), ok);
        round_clr = 1'b1; in_valid = 1'b1; in_card = cd(0, 9);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL clr_ready_low: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        round_clr = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || win_valid !== 1'b0) begin
            errors++; $display("FAIL clr_after: in_ready=%b res_valid=%b win_valid=%b required 1/0/0", in_ready, res_valid, win_valid);
        end
        @(negedge clk);
        hands[0] = mk5(cd(0, 6), cd(1, 6), cd(2, 6), cd(3, 6), cd(0, 2));
        hands[1] = mk5(cd(0, 9), cd(1, 9), cd(2, 4), cd(3, 3), cd(0, 2));
        hands[2] = mk5(cd(0, 12), cd(1, 9), cd(2, 4), cd(3, 3), cd(0, 2));
        hands[3] = mk5(cd(0, 8), cd(1, 8), cd(2, 5), cd(3, 5), cd(0, 2));
        for (int p = 0; p < NP; p++) begin
            ref_hand(hands[p], ecat, esc, eer);
            scs[24*p +: 24] = esc; ers[p] = eer;
            play_hand(hands[p], cat, sc, er, pl, wv, wp, wt, ok);
            checks++;
            if (!ok || pl !== 2'(p) || cat !== ecat || sc !== esc || er !== eer) begin
                errors++; $display("FAIL clr_new_hand%0d: ok=%b player=%0d cat=%0d score=%h required %0d/%0d/%h", p, ok, pl, cat, sc, p, ecat, esc);
            end
        end
        ref_winner(scs, ers, ewp, ewt);
        checks++;
        if (wv !== 1'b1 || wp !== ewp || wt !== ewt) begin
            errors++; $display("FAIL clr_winner: wv=%b wp=%0d tie=%b required 1/%0d/%b", wv, wp, wt, ewp, ewt);
        end
    endtask

    task automatic test_reset_mid_hand;
        logic [29:0] h;
        logic [3:0] cat, ecat; logic [23:0] sc, esc; logic er, eer, wv, wt; logic [1:0] pl, wp;
        bit ok;
        play_hand(rand_hand(0), cat, sc, er, pl, wv, wp, wt, ok);
        send_card(cd(1, 3), ok);
        send_card(cd(2, 11), ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_player !== 2'd0) begin
            errors++; $display("FAIL rst_mid_outputs: in_ready=%b res_valid=%b player=%0d required 0/0/0", in_ready, res_valid, res_player);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ready: in_ready=%b required 1", in_ready);
        end
        h = mk5(cd(0, 10), cd(1, 2), cd(2, 10), cd(3, 14), cd(0, 2));
        ref_hand(h, ecat, esc, eer);
        play_hand(h, cat, sc, er, pl, wv, wp, wt, ok);
        checks++;
        if (!ok || pl !== 2'd0 || cat !== ecat || sc !== esc || er !== eer || wv !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fresh: ok=%b player=%0d cat=%0d score=%h required 0/%0d/%h", ok, pl, cat, sc, ecat, esc);
        end
        for (int p = 1; p < NP; p++) play_hand(rand_hand(0), cat, sc, er, pl, wv, wp, wt, ok);
        checks++;
        if (!ok || wv !== 1'b1 || pl !== 2'd3) begin
            errors++; $display("FAIL rst_mid_round_end: ok=%b wv=%b player=%0d required 1/1/3", ok, wv, pl);
        end
    endtask

    task automatic test_random_rounds;
        logic [29:0] h;
        logic [95:0] scs; logic [3:0] ers;
        logic [3:0] cat, ecat; logic [23:0] sc, esc; logic er, eer, wv, wt, ewt; logic [1:0] pl, wp, ewp;
        bit ok;
        for (int rnd = 0; rnd < 30; rnd++) begin
            for (int p = 0; p < NP; p++) begin
                h = rand_hand($urandom_range(4, 0));
                ref_hand(h, ecat, esc, eer);
                scs[24*p +: 24] = esc; ers[p] = eer;
                play_hand(h, cat, sc, er, pl, wv, wp, wt, ok);
                checks++;
                if (!ok || pl !== 2'(p) || cat !== ecat || sc !== esc || er !== eer || wv !== (p == NP - 1)) begin
                    errors++; $display("FAIL rand_hand r%0d p%0d hand=%h: ok=%b player=%0d cat=%0d score=%h err=%b wv=%b required cat=%0d score=%h err=%b", rnd, p, h, ok, pl, cat, sc, er, wv, ecat, esc, eer);
                end
            end
            ref_winner(scs, ers, ewp, ewt);
            checks++;
            if (wp !== ewp || wt !== ewt) begin
                errors++; $display("FAIL rand_winner r%0d: wp=%0d tie=%b required %0d/%b", rnd, wp, wt, ewp, ewt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_royal_latency();
        test_wheel();
        test_full_house();
        test_duplicate();
        test_tie();
        test_backpressure();
        test_round_clr();
        test_reset_mid_hand();
        test_random_rounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
